// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter sharing one 4-bit 4:1 mux between four requesters over a valid/ready port.
// Optional burst mode (hold grant up to BURST_LEN transfers) is enabled by defining RR_ARB_BURST_EN.
module mux_4_1_rr_arbiter #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic [3:0] ack
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic       valid_q, valid_d;

  logic       xfer;
  logic       keep;
  logic [1:0] base;
  logic [1:0] win_idx;
  logic [3:0] mux_a, mux_b, mux_o;

  assign xfer = valid_q & out_ready;
  // On a transfer the current owner becomes "last" in the same cycle it is re-arbitrated.
  assign base = xfer ? sel_q : last_q;

  always_comb begin
    win_idx = base;
    // Offsets scanned 0(=4),3,2,1: later hits override, so the nearest offset after base wins.
    for (int unsigned i = 0; i < 4; i++) begin
      if (req[base + 2'(4 - i)]) win_idx = base + 2'(4 - i);
    end
  end

`ifdef RR_ARB_BURST_EN
  logic [3:0] cnt_q, cnt_d;

  assign keep = req[sel_q] && (cnt_q < 4'(BURST_LEN - 1));
`else
  logic unused_burst_len;

  assign keep             = 1'b0;
  assign unused_burst_len = ^4'(BURST_LEN);
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    valid_d = valid_q;
`ifdef RR_ARB_BURST_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          grant_d = 4'b0001 << win_idx;
          sel_d   = win_idx;
          valid_d = 1'b1;
`ifdef RR_ARB_BURST_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (out_ready) begin
          if (keep) begin
`ifdef RR_ARB_BURST_EN
            cnt_d = cnt_q + 4'd1;
`endif
          end else begin
            last_d = sel_q;
            if (|req) begin
              grant_d = 4'b0001 << win_idx;
              sel_d   = win_idx;
`ifdef RR_ARB_BURST_EN
              cnt_d   = '0;
`endif
            end else begin
              state_d = IDLE;
              grant_d = '0;
              valid_d = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= '1;
      valid_q <= 1'b0;
`ifdef RR_ARB_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      valid_q <= valid_d;
`ifdef RR_ARB_BURST_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign mux_a = sel_q[0] ? d1 : d0;
  assign mux_b = sel_q[0] ? d3 : d2;
  assign mux_o = sel_q[1] ? mux_b : mux_a;

  assign out_valid = valid_q;
  assign out_data  = valid_q ? mux_o : '0;
  assign grant     = grant_q;
  assign sel       = sel_q;
  assign ack       = grant_q & {4{xfer}};

endmodule
